// File: rtl/nn_weight_loader_pkg.sv
// nn_weight_loader_pkg: NN parameter BRAM layout, section/state types and section decode
package nn_weight_loader_pkg;

   localparam logic [9:0] WEIGHT_1 = 10'h000;
   localparam logic [9:0] BIAS_1   = 10'h310;
   localparam logic [9:0] WEIGHT_2 = 10'h311;
   localparam logic [9:0] BIAS_2   = 10'h325;
   localparam logic [9:0] WEIGHT_3 = 10'h326;
   localparam logic [9:0] BIAS_3   = 10'h33A;

   localparam logic [9:0] LOAD_LAST_ADDR = BIAS_3;
   localparam int         WORDS_TOTAL    = 827;

   typedef enum logic [2:0] {
      SEC_W1   = 3'd0,
      SEC_B1   = 3'd1,
      SEC_W2   = 3'd2,
      SEC_B2   = 3'd3,
      SEC_W3   = 3'd4,
      SEC_B3   = 3'd5,
      SEC_NONE = 3'd7
   } nn_section_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } nn_load_state_t;

   function automatic nn_section_t section_of(input logic [9:0] a);
      return a <  BIAS_1   ? SEC_W1 :
             a <  WEIGHT_2 ? SEC_B1 :
             a <  BIAS_2   ? SEC_W2 :
             a <  WEIGHT_3 ? SEC_B2 :
             a <  BIAS_3   ? SEC_W3 :
             a == BIAS_3   ? SEC_B3 : SEC_NONE;
   endfunction

endpackage

// File: rtl/nn_weight_loader_packer.sv
// byte_word_packer: assembles little-endian bytes into words, one-cycle word_valid pulse per word
module byte_word_packer #(
   parameter int WORD_BYTES = 2,
   parameter int DATA_W     = 8 * WORD_BYTES
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              clear,
   input  logic [7:0]        byte_in,
   input  logic              valid,
   output logic [DATA_W-1:0] word,
   output logic              word_valid
);

   localparam int CW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;

   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] sr;
   logic [DATA_W-1:0] sr_nxt;
   logic              last;

   assign sr_nxt = (sr >> 8) | (DATA_W'(byte_in) << (DATA_W - 8));
   assign last   = cnt == CW'(WORD_BYTES - 1);

   // shift bytes in from the top so the first byte lands in bits [7:0]; publish on the last byte
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt        <= '0;
         sr         <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            cnt <= '0;
         end else if (valid) begin
            sr  <= sr_nxt;
            cnt <= last ? '0 : cnt + CW'(1);
            if (last) begin
               word       <= sr_nxt;
               word_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/nn_weight_loader.sv
// nn_weight_loader: streams bytes into the NN parameter BRAM and verifies the trailing checksum
module nn_weight_loader
   import nn_weight_loader_pkg::*;
#(
   parameter int WORD_BYTES = 2,
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 10
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wdata,
   output logic [2:0]        section,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LOAD_LAST_ADDR);

   nn_load_state_t    state;
   nn_load_state_t    state_nxt;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        sum;
   logic [7:0]        sum_nxt;
   logic              load_st;
   logic              fire;
   logic              word_valid;
   logic              last_wr;
   logic              sum_ok;

   assign load_st = state == ST_LOAD;
   assign fire    = in_valid && (load_st || state == ST_CHECK);
   assign sum_nxt = sum + in_data;
   assign sum_ok  = sum_nxt == 8'h00;
   assign last_wr = load_st && word_valid && addr == LAST;

   byte_word_packer #(
      .WORD_BYTES(WORD_BYTES),
      .DATA_W    (DATA_W)
   ) u_packer (
      .Clk       (Clk),
      .Reset     (Reset),
      .clear     (start),
      .byte_in   (in_data),
      .valid     (fire && load_st),
      .word      (bram_wdata),
      .word_valid(word_valid)
   );

   // state register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // next state and outputs; a checksum byte arriving alongside the final write is judged at once
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      bram_we   = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      section   = SEC_NONE;
      case (state)
         ST_LOAD: begin
            in_ready  = 1'b1;
            busy      = 1'b1;
            bram_we   = word_valid;
            section   = section_of(10'(addr));
            state_nxt = !last_wr ? ST_LOAD : !fire ? ST_CHECK : sum_ok ? ST_DONE : ST_ERROR;
         end
         ST_CHECK: begin
            in_ready  = 1'b1;
            busy      = 1'b1;
            state_nxt = !fire ? ST_CHECK : sum_ok ? ST_DONE : ST_ERROR;
         end
         ST_DONE:  done = 1'b1;
         ST_ERROR: err  = 1'b1;
         default:  state_nxt = state;
      endcase
      if (start) state_nxt = ST_LOAD;
   end

   assign bram_addr = addr;

   // write address advances after each write and parks on the last word; running byte sum
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         addr <= '0;
         sum  <= '0;
      end else if (start) begin
         addr <= '0;
         sum  <= '0;
      end else begin
         if (load_st && word_valid && addr != LAST) addr <= addr + ADDR_W'(1);
         if (load_st && fire) sum <= sum_nxt;
      end
   end

endmodule
